// File: rtl/function_operand_sequencer.sv
// function_operand_sequencer
//
// Sequential front/back end for the 8-bit combinational function unit
// (out = (a | b) - b, i.e. a & ~b). Operand A and then operand B arrive over
// a valid/ready byte stream. They are held in registers that drive the
// function unit. After EXEC_CYCLES settle edges the unit's result is
// captured and offered on a valid/ready result port.
//
// Optional build macro: FUNC_SEQ_CHECK_EN
//   When defined, each captured result is compared with op_a & ~op_b, and a
//   mismatch sets the sticky chk_err flag. When undefined, chk_err is tied
//   to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/ready   operand byte stream (A first, then B)
//   a_out, b_out          registered operands to the function unit
//   fu_in                 function unit result
//   res_data/valid/ready  captured result stream
//   busy                  operation in progress (waiting for B, settling,
//                         or holding a result)
//   op_count              completed result handshakes, wraps silently
//   chk_err               sticky self-check error (checker builds only)
module function_operand_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   fu_in,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count,
    output logic               chk_err
);

    // A settle time of zero is not meaningful; clamp it to one edge.
    localparam int unsigned EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
    localparam int unsigned CNT_W    = $clog2(EXEC_EFF + 1);

    typedef enum logic [1:0] {StA, StB, StExec, StOut} state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [CNT_W-1:0]   cnt;
    logic               a_pend;
    logic               in_xfer;
    logic               res_xfer;
    logic               capture;

    // Once a result is held, only one early A can be buffered (a_pend).
    assign in_ready = (state == StA) || (state == StB) || ((state == StOut) && !a_pend);
    assign in_xfer  = in_valid && in_ready;
    assign res_xfer = res_valid && res_ready;
    assign capture  = (state == StExec) && (cnt == CNT_W'(1));
    assign busy     = (state != StA);
    assign a_out    = op_a;
    assign b_out    = op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StA;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            a_pend    <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            unique case (state)
                StA: begin
                    if (in_xfer) begin
                        op_a  <= in_data;
                        state <= StB;
                    end
                end
                StB: begin
                    if (in_xfer) begin
                        op_b  <= in_data;
                        cnt   <= CNT_W'(EXEC_EFF);
                        state <= StExec;
                    end
                end
                StExec: begin
                    if (capture) begin
                        res_data  <= fu_in;
                        res_valid <= 1'b1;
                        state     <= StOut;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                StOut: begin
                    // The result is already captured, so reloading op_a here
                    // cannot disturb res_data.
                    if (in_xfer) begin
                        op_a <= in_data;
                    end
                    if (res_xfer) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + COUNT_W'(1);
                        a_pend    <= 1'b0;
                        state     <= (a_pend || in_xfer) ? StB : StA;
                    end else if (in_xfer) begin
                        a_pend <= 1'b1;
                    end
                end
                default: state <= StA;
            endcase
        end
    end

`ifdef FUNC_SEQ_CHECK_EN
    logic chk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (capture && (fu_in != (op_a & ~op_b))) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_function_operand_sequencer.sv
// Bench for function_operand_sequencer. Instance 0 uses EXEC_CYCLES=1 and
// COUNT_W=16. Instance 1 uses EXEC_CYCLES=4 and COUNT_W=2, which covers the
// long settle time and op_count wrap. Expected results are pushed into a
// queue for each instance when B is sent, and popped when res_valid rises.
module tb_function_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a_out     [2];
    logic [7:0] b_out     [2];
    logic [7:0] fu_in     [2];
    logic [7:0] res_data  [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic       busy      [2];
    logic [15:0] op_cnt   [2];
    logic       chk_err   [2];
    logic [15:0] op_cnt0;
    logic [1:0]  op_cnt1;

    // Override of the function unit output, used to provoke a check error.
    logic       force_fu  [2];
    logic [7:0] force_val;

    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    int n_assert;
    int n_fail;
    logic exp_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function unit as attached in the system: (a | b) - b.
    assign fu_in[0] = force_fu[0] ? force_val : (a_out[0] | b_out[0]) - b_out[0];
    assign fu_in[1] = force_fu[1] ? force_val : (a_out[1] | b_out[1]) - b_out[1];
    assign op_cnt[0] = op_cnt0;
    assign op_cnt[1] = {14'd0, op_cnt1};

    function_operand_sequencer #(.WIDTH(8), .EXEC_CYCLES(1), .COUNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_out(a_out[0]), .b_out(b_out[0]), .fu_in(fu_in[0]),
        .res_data(res_data[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .busy(busy[0]), .op_count(op_cnt0), .chk_err(chk_err[0])
    );

    function_operand_sequencer #(.WIDTH(8), .EXEC_CYCLES(4), .COUNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_out(a_out[1]), .b_out(b_out[1]), .fu_in(fu_in[1]),
        .res_data(res_data[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .busy(busy[1]), .op_count(op_cnt1), .chk_err(chk_err[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        return a & ~b;
    endfunction

    task automatic sb_push(input int i, input logic [7:0] v);
        if (i == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    // Presents one byte and returns 1 ns after the edge that accepts it.
    task automatic send_byte(input int i, input logic [7:0] d, input string tag);
        int w = 0;
        in_data[i]  = d;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && w < 64) begin
            tick();
            w++;
        end
        chk({tag, "_accept_timeout"}, (w < 64), 1'b1);
        tick();
        in_valid[i] = 1'b0;
    endtask

    task automatic send_op(input int i, input logic [7:0] a, input logic [7:0] b,
                           input string tag);
        send_byte(i, a, {tag, "_a"});
        send_byte(i, b, {tag, "_b"});
        sb_push(i, model(a, b));
    endtask

    // Call right after the B-accept edge. Checks latency, in_ready low while
    // settling, and the result data against the scoreboard.
    task automatic wait_result(input int i, input int exp_lat, input string tag);
        int lat = 0;
        logic saw_ready = 1'b0;
        logic [7:0] exp;
        while (!res_valid[i] && lat < 64) begin
            if (in_ready[i]) saw_ready = 1'b1;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_in_ready_exec"}, saw_ready, 1'b0);
        if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            exp = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            chk({tag, "_data"}, res_data[i], exp);
        end
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk({tag, "_in_ready"}, in_ready[i], 1'b1);
        chk({tag, "_busy"}, busy[i], 1'b0);
        chk({tag, "_res_valid"}, res_valid[i], 1'b0);
        chk({tag, "_res_data"}, res_data[i], 8'h00);
        chk({tag, "_a_out"}, a_out[i], 8'h00);
        chk({tag, "_b_out"}, b_out[i], 8'h00);
        chk({tag, "_op_count"}, op_cnt[i], 16'd0);
        chk({tag, "_chk_err"}, chk_err[i], 1'b0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
`ifdef FUNC_SEQ_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        rst_n = 1'b0;
        force_val = 8'h00;
        for (int i = 0; i < 2; i++) begin
            in_data[i]   = 8'h00;
            in_valid[i]  = 1'b0;
            res_ready[i] = 1'b1;
            force_fu[i]  = 1'b0;
        end
        #12;
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        rst_n = 1'b1;
        tick();

        // Basic operation, one settle edge.
        send_op(0, 8'hF0, 8'h3C, "basic");
        wait_result(0, 1, "basic");
        tick();
        chk("basic_op_count", op_cnt[0], 16'd1);
        chk("basic_in_ready", in_ready[0], 1'b1);
        chk("basic_busy", busy[0], 1'b0);
        chk("basic_res_valid_drop", res_valid[0], 1'b0);

        // Four settle edges.
        send_op(1, 8'hFF, 8'h0F, "exec4");
        wait_result(1, 4, "exec4");
        tick();
        chk("exec4_op_count", op_cnt[1], 16'd1);

        // Backpressure with an early A buffered during the held result.
        res_ready[0] = 1'b0;
        send_op(0, 8'hAA, 8'h00, "bp");
        wait_result(0, 1, "bp");
        tick();
        tick();
        send_byte(0, 8'h55, "bp_early_a");
        chk("bp_in_ready_after_a", in_ready[0], 1'b0);
        chk("bp_res_hold", res_data[0], 8'hAA);
        tick();
        tick();
        tick();
        chk("bp_res_hold_late", res_data[0], 8'hAA);
        chk("bp_res_valid_hold", res_valid[0], 1'b1);
        chk("bp_a_out", a_out[0], 8'h55);
        res_ready[0] = 1'b1;
        tick();
        chk("bp_op_count", op_cnt[0], 16'd2);
        chk("bp_state_b_busy", busy[0], 1'b1);
        chk("bp_state_b_ready", in_ready[0], 1'b1);
        send_byte(0, 8'h01, "bp_b");
        sb_push(0, model(8'h55, 8'h01));
        wait_result(0, 1, "bp2");
        tick();
        chk("bp2_op_count", op_cnt[0], 16'd3);

        // Result handshake and next A accepted on the same edge.
        res_ready[0] = 1'b0;
        send_op(0, 8'h0F, 8'h03, "simul");
        wait_result(0, 1, "simul");
        res_ready[0] = 1'b1;
        in_data[0]   = 8'h81;
        in_valid[0]  = 1'b1;
        tick();
        in_valid[0]  = 1'b0;
        chk("simul_op_count", op_cnt[0], 16'd4);
        chk("simul_busy", busy[0], 1'b1);
        chk("simul_in_ready", in_ready[0], 1'b1);
        chk("simul_a_out", a_out[0], 8'h81);
        send_byte(0, 8'h80, "simul_b");
        sb_push(0, model(8'h81, 8'h80));
        wait_result(0, 1, "simul2");
        tick();
        chk("simul2_op_count", op_cnt[0], 16'd5);

        // Asynchronous reset in the middle of the settle time.
        send_byte(1, 8'h12, "abort_a");
        send_byte(1, 8'h34, "abort_b");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(1, "arst1");
        chk("arst0_op_count", op_cnt[0], 16'd0);
        rst_n = 1'b1;
        tick();
        send_op(1, 8'h0F, 8'h0F, "post_rst");
        wait_result(1, 4, "post_rst");
        tick();
        chk("post_rst_op_count", op_cnt[1], 16'd1);

        // op_count wrap on the 2-bit counter.
        for (int k = 2; k <= 4; k++) begin
            send_op(1, 8'($urandom), 8'($urandom), "wrap");
            wait_result(1, 4, "wrap");
            tick();
            chk("wrap_op_count", op_cnt[1], 16'(k % 4));
        end

        // Faulty function unit output. chk_err depends on the build.
        force_val   = 8'h01;
        force_fu[0] = 1'b1;
        send_byte(0, 8'h00, "chk_a");
        send_byte(0, 8'h00, "chk_b");
        sb_push(0, 8'h01);
        wait_result(0, 1, "chk");
        force_fu[0] = 1'b0;
        tick();
        chk("chk_err_set", chk_err[0], exp_chk);
        send_op(0, 8'h3C, 8'h0F, "chk_sticky");
        wait_result(0, 1, "chk_sticky");
        tick();
        chk("chk_err_sticky", chk_err[0], exp_chk);
        chk("chk_op_count", op_cnt[0], 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
